// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Multi-cycle MIPS subset core. Every instruction walks FETCH/DECODE/EXEC/
//   MEM/WB over one shared ALU. The core stops in HALT on syscall (a normal
//   stop) or on an unsupported encoding (flagged as ILLEGAL).
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   IMEM_WE/WADDR/  instruction-memory load port; writes are only accepted
//   IMEM_WDATA      while in reset or halted
//   DBG_RADDR/DATA  combinational debug read of the register file
//   PC_OUT          current PC
//   STATE_OUT       FSM state (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5)
//   RETIRED         completed-instruction counter (wraps)
//   HALTED/ILLEGAL  stopped / stopped on an unsupported encoding
module mips_multicycle_core #(
  parameter int          IMEM_AW  = 5,
  parameter int          DMEM_AW  = 5,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IMEM_WE,
  input  logic [IMEM_AW-1:0] IMEM_WADDR,
  input  logic [31:0]        IMEM_WDATA,
  input  logic [4:0]         DBG_RADDR,
  output logic [31:0]        DBG_RDATA,
  output logic [31:0]        PC_OUT,
  output logic [2:0]         STATE_OUT,
  output logic [31:0]        RETIRED,
  output logic               HALTED,
  output logic               ILLEGAL
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_SLTIU = 6'h0B,
                         OP_LW    = 6'h23, OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SYSCALL = 6'h0C, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                         FN_AND     = 6'h24, FN_OR   = 6'h25, FN_SLT  = 6'h2A,
                         FN_SLTU    = 6'h2B;

  logic [31:0] imem [2**IMEM_AW];
  logic [31:0] dmem [2**DMEM_AW];
  logic [31:0] regs_q [32];

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d;
  logic [31:0] retired_q, retired_d, ir_q, mdr_q;
  logic        halted_q, halted_d, illegal_q, illegal_d;

  logic        rf_we, dm_we, legal;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pc_plus4;

  wire [5:0]  op    = ir_q[31:26];
  wire [4:0]  rs    = ir_q[25:21];
  wire [4:0]  rt    = ir_q[20:16];
  wire [4:0]  rd    = ir_q[15:11];
  wire [5:0]  funct = ir_q[5:0];
  wire [31:0] sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  wire        is_syscall = (op == OP_RTYPE) && (funct == FN_SYSCALL);
  wire [DMEM_AW-1:0] dmem_idx = alu_q[DMEM_AW+1:2];

  assign pc_plus4  = pc_q + 32'd4;
  assign DBG_RDATA = regs_q[DBG_RADDR];
  assign PC_OUT    = pc_q;
  assign STATE_OUT = state_q;
  assign RETIRED   = retired_q;
  assign HALTED    = halted_q;
  assign ILLEGAL   = illegal_q;

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = (funct == FN_ADDU) || (funct == FN_SUBU) ||
                        (funct == FN_AND)  || (funct == FN_OR)   ||
                        (funct == FN_SLT)  || (funct == FN_SLTU);
      OP_J, OP_BEQ, OP_BNE, OP_ADDIU, OP_SLTIU, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_q;
    dm_we     = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        a_d   = regs_q[rs];
        b_d   = regs_q[rt];
        imm_d = sext;
        if (is_syscall) begin
          // syscall completes here, so it counts as retired; PC stays on it
          state_d   = S_HALT;
          halted_d  = 1'b1;
          retired_d = retired_q + 32'd1;
        end else if (!legal) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (op)
          OP_RTYPE: begin
            case (funct)
              FN_ADDU: alu_d = a_q + b_q;
              FN_SUBU: alu_d = a_q - b_q;
              FN_AND:  alu_d = a_q & b_q;
              FN_OR:   alu_d = a_q | b_q;
              FN_SLT:  alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
              default: alu_d = {31'd0, a_q < b_q};
            endcase
          end
          OP_ADDIU: alu_d = a_q + imm_q;
          OP_SLTIU: alu_d = {31'd0, a_q < imm_q};
          OP_LW, OP_SW: begin
            alu_d   = a_q + imm_q;
            state_d = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            if ((a_q == b_q) == (op == OP_BEQ))
              pc_d = pc_plus4 + {imm_q[29:0], 2'b00};
            else
              pc_d = pc_plus4;
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
          default: begin // OP_J, the only remaining legal opcode
            pc_d      = {pc_plus4[31:28], ir_q[25:0], 2'b00};
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (op == OP_SW) begin
          dm_we     = 1'b1;
          pc_d      = pc_plus4;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_waddr  = (op == OP_RTYPE) ? rd : rt;
        rf_wdata  = (op == OP_LW) ? mdr_q : alu_q;
        pc_d      = pc_plus4;
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Instruction memory: loads only while the core is parked; fetch wraps on
  // the low PC word bits.
  always_ff @(posedge CLK) begin
    if (IMEM_WE && (RST || halted_q))
      imem[IMEM_WADDR] <= IMEM_WDATA;
    if (state_q == S_FETCH)
      ir_q <= imem[pc_q[IMEM_AW+1:2]];
  end

  // Data memory is not cleared by reset; a store racing a reset is dropped.
  always_ff @(posedge CLK) begin
    if (dm_we && !RST)
      dmem[dmem_idx] <= b_q;
    if (state_q == S_MEM)
      mdr_q <= dmem[dmem_idx];
  end

  // Register 0 is never written, so with the reset clear it always reads 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++)
        regs_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_we = 1'b0;
  logic [4:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata, pc_out, retired;
  logic [2:0]  state_out;
  logic        halted, illegal;

  always #5 clk = ~clk;

  mips_multicycle_core #(.IMEM_AW(5), .DMEM_AW(5), .RESET_PC(32'h0)) dut (
    .CLK(clk), .RST(rst), .IMEM_WE(imem_we), .IMEM_WADDR(imem_waddr),
    .IMEM_WDATA(imem_wdata), .DBG_RADDR(dbg_raddr), .DBG_RDATA(dbg_rdata),
    .PC_OUT(pc_out), .STATE_OUT(state_out), .RETIRED(retired),
    .HALTED(halted), .ILLEGAL(illegal)
  );

  localparam int K_REG = 0, K_PC = 1, K_RET = 2, K_HALT = 3, K_ILL = 4,
                 K_STATE = 5, K_CYC = 6;
  localparam logic [31:0] SYSCALL = 32'h0000_000C;
  localparam logic [31:0] BADOP   = 32'hFC00_0000;

  typedef struct {
    string       name;
    int          kind;
    logic [4:0]  idx;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] obs;
  logic [31:0] prog [32];
  int          cycles;
  int          passed = 0;
  int          total = 0;

  function automatic logic [31:0] r_ins(input int s, input int t, input int d, input logic [5:0] fn);
    r_ins = {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int s, input int t, input logic [15:0] imm);
    i_ins = {op, 5'(s), 5'(t), imm};
  endfunction

  task automatic push(input string name, input int kind, input int idx, input logic [31:0] exp);
    exp_t x;
    x.name = name; x.kind = kind; x.idx = 5'(idx); x.exp = exp;
    sb.push_back(x);
  endtask

  task automatic observe(input int kind, input logic [4:0] idx, output logic [31:0] o);
    case (kind)
      K_REG:   begin dbg_raddr = idx; #1; o = dbg_rdata; end
      K_PC:    o = pc_out;
      K_RET:   o = retired;
      K_HALT:  o = {31'd0, halted};
      K_ILL:   o = {31'd0, illegal};
      K_STATE: o = {29'd0, state_out};
      default: o = 32'(cycles);
    endcase
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = BADOP;
  endtask

  // Holds reset while writing all 32 words; leaves RST asserted.
  task automatic load_prog();
    rst = 1'b1;
    imem_we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      imem_waddr = 5'(i);
      imem_wdata = prog[i];
      @(posedge clk); #1;
    end
    imem_we = 1'b0;
  endtask

  task automatic run_until_halt();
    while (halted !== 1'b1 && cycles < 500) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    clear_prog();
    prog[0] = i_ins(6'h09, 0, 8, 16'd5);
    prog[1] = i_ins(6'h09, 0, 9, 16'd7);
    prog[2] = r_ins(8, 9, 10, 6'h21);
    prog[3] = SYSCALL;
    load_prog();
    push("rst_state", K_STATE, 0, 32'd0);
    push("rst_pc", K_PC, 0, 32'd0);
    push("rst_retired", K_RET, 0, 32'd0);
    push("rst_halted", K_HALT, 0, 32'd0);
    push("rst_reg10", K_REG, 10, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      observe(e.kind, e.idx, obs);
      total++;
      if (obs !== e.exp) $display("FAIL reset/%s: got %h expected %h", e.name, obs, e.exp);
      else begin passed++; $display("reset/%s: got %h ok", e.name, obs); end
    end
  endtask

  task automatic test_alu_basic();
    push("cycles", K_CYC, 0, 32'd14);
    push("reg10", K_REG, 10, 32'd12);
    push("retired", K_RET, 0, 32'd4);
    push("pc", K_PC, 0, 32'd12);
    push("illegal", K_ILL, 0, 32'd0);
    rst = 1'b0; cycles = 0;
    run_until_halt();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      observe(e.kind, e.idx, obs);
      total++;
      if (obs !== e.exp) $display("FAIL basic/%s: got %h expected %h", e.name, obs, e.exp);
      else begin passed++; $display("basic/%s: got %h ok", e.name, obs); end
    end
  endtask

  task automatic test_memory();
    clear_prog();
    prog[0] = i_ins(6'h09, 0, 8, 16'h002C);
    prog[1] = i_ins(6'h2B, 0, 8, 16'd4);
    prog[2] = i_ins(6'h23, 0, 9, 16'd4);
    prog[3] = SYSCALL;
    load_prog();
    push("cycles", K_CYC, 0, 32'd15);
    push("reg9", K_REG, 9, 32'h2C);
    push("retired", K_RET, 0, 32'd4);
    rst = 1'b0; cycles = 0;
    run_until_halt();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      observe(e.kind, e.idx, obs);
      total++;
      if (obs !== e.exp) $display("FAIL mem/%s: got %h expected %h", e.name, obs, e.exp);
      else begin passed++; $display("mem/%s: got %h ok", e.name, obs); end
    end
  endtask

  task automatic test_branch_loop();
    clear_prog();
    prog[0] = i_ins(6'h09, 0, 9, 16'd4);
    prog[1] = i_ins(6'h09, 8, 8, 16'd1);
    prog[2] = i_ins(6'h05, 8, 9, 16'hFFFE);
    prog[3] = SYSCALL;
    load_prog();
    // 4 + 4 iterations * (addiu 4 + bne 3) + syscall 2
    push("cycles", K_CYC, 0, 32'd34);
    push("reg8", K_REG, 8, 32'd4);
    push("retired", K_RET, 0, 32'd10);
    push("pc", K_PC, 0, 32'd12);
    rst = 1'b0; cycles = 0;
    run_until_halt();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      observe(e.kind, e.idx, obs);
      total++;
      if (obs !== e.exp) $display("FAIL loop/%s: got %h expected %h", e.name, obs, e.exp);
      else begin passed++; $display("loop/%s: got %h ok", e.name, obs); end
    end
  endtask

  task automatic test_zero_compare();
    clear_prog();
    prog[0] = i_ins(6'h09, 0, 0, 16'd9);
    prog[1] = i_ins(6'h0B, 0, 8, 16'hFFFF);
    prog[2] = i_ins(6'h09, 0, 10, 16'hFFFF);
    prog[3] = i_ins(6'h09, 0, 11, 16'd1);
    prog[4] = r_ins(10, 11, 9, 6'h2A);
    prog[5] = r_ins(10, 11, 12, 6'h2B);
    prog[6] = r_ins(11, 10, 13, 6'h23);
    prog[7] = r_ins(10, 11, 14, 6'h24);
    prog[8] = r_ins(11, 13, 15, 6'h25);
    prog[9] = SYSCALL;
    load_prog();
    push("cycles", K_CYC, 0, 32'd38);
    push("reg0", K_REG, 0, 32'd0);
    push("sltiu_reg8", K_REG, 8, 32'd1);
    push("reg10", K_REG, 10, 32'hFFFF_FFFF);
    push("slt_reg9", K_REG, 9, 32'd1);
    push("sltu_reg12", K_REG, 12, 32'd0);
    push("subu_reg13", K_REG, 13, 32'd2);
    push("and_reg14", K_REG, 14, 32'd1);
    push("or_reg15", K_REG, 15, 32'd3);
    push("retired", K_RET, 0, 32'd10);
    rst = 1'b0; cycles = 0;
    run_until_halt();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      observe(e.kind, e.idx, obs);
      total++;
      if (obs !== e.exp) $display("FAIL cmp/%s: got %h expected %h", e.name, obs, e.exp);
      else begin passed++; $display("cmp/%s: got %h ok", e.name, obs); end
    end
  endtask

  task automatic test_jump_illegal();
    clear_prog();
    prog[0] = {6'h02, 26'd6};
    for (int i = 1; i < 6; i++) prog[i] = i_ins(6'h09, 0, 8, 16'd1);
    prog[6] = BADOP;
    load_prog();
    push("cycles", K_CYC, 0, 32'd5);
    push("illegal", K_ILL, 0, 32'd1);
    push("halted", K_HALT, 0, 32'd1);
    push("pc", K_PC, 0, 32'd24);
    push("retired", K_RET, 0, 32'd1);
    push("skipped_reg8", K_REG, 8, 32'd0);
    rst = 1'b0; cycles = 0;
    run_until_halt();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      observe(e.kind, e.idx, obs);
      total++;
      if (obs !== e.exp) $display("FAIL jump/%s: got %h expected %h", e.name, obs, e.exp);
      else begin passed++; $display("jump/%s: got %h ok", e.name, obs); end
    end
  endtask

  task automatic test_reset_mid_lw();
    clear_prog();
    prog[0] = i_ins(6'h09, 0, 8, 16'h0055);
    prog[1] = i_ins(6'h2B, 0, 8, 16'd0);
    prog[2] = i_ins(6'h23, 0, 9, 16'd0);
    prog[3] = SYSCALL;
    load_prog();
    rst = 1'b0; cycles = 0;
    // addiu 4 + sw 4 + lw FETCH/DECODE/EXEC 3 edges -> lw sits in MEM
    for (int i = 0; i < 11; i++) begin @(posedge clk); #1; end
    push("in_mem_state", K_STATE, 0, 32'd3);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      observe(e.kind, e.idx, obs);
      total++;
      if (obs !== e.exp) $display("FAIL midlw/%s: got %h expected %h", e.name, obs, e.exp);
      else begin passed++; $display("midlw/%s: got %h ok", e.name, obs); end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    push("reg9_dropped", K_REG, 9, 32'd0);
    push("pc", K_PC, 0, 32'd0);
    push("state", K_STATE, 0, 32'd0);
    push("retired", K_RET, 0, 32'd0);
    push("halted", K_HALT, 0, 32'd0);
    push("illegal_cleared", K_ILL, 0, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      observe(e.kind, e.idx, obs);
      total++;
      if (obs !== e.exp) $display("FAIL midlw/%s: got %h expected %h", e.name, obs, e.exp);
      else begin passed++; $display("midlw/%s: got %h ok", e.name, obs); end
    end
    // Rerun; an IMEM write while running must not replace the syscall.
    rst = 1'b0;
    imem_we = 1'b1; imem_waddr = 5'd3; imem_wdata = BADOP;
    @(posedge clk); #1;
    imem_we = 1'b0;
    cycles = 1;
    push("rerun_cycles", K_CYC, 0, 32'd15);
    push("rerun_illegal", K_ILL, 0, 32'd0);
    push("rerun_pc", K_PC, 0, 32'd12);
    push("rerun_reg9", K_REG, 9, 32'h55);
    push("rerun_retired", K_RET, 0, 32'd4);
    run_until_halt();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      observe(e.kind, e.idx, obs);
      total++;
      if (obs !== e.exp) $display("FAIL midlw/%s: got %h expected %h", e.name, obs, e.exp);
      else begin passed++; $display("midlw/%s: got %h ok", e.name, obs); end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_alu_basic();
    test_memory();
    test_branch_loop();
    test_zero_compare();
    test_jump_illegal();
    test_reset_mid_lw();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
